// File: rtl/arp_response_core.sv
// ARP responder: parses received Ethernet/ARP frames and, for a request
// aimed at MY_IPV4, offers a 42-byte reply on a byte stream gated by an ACK.
module arp_response_core (
  input  logic        CLK_RX,
  input  logic        ARESET,
  input  logic [47:0] MY_MAC,
  input  logic [31:0] MY_IPV4,
  input  logic        DATA_VALID_RX,
  input  logic [7:0]  DATA_RX,
  output logic        DATA_VALID_TX,
  output logic [7:0]  DATA_TX,
  input  logic        DATA_ACK_TX
);

  localparam int unsigned CntW     = 6;
  localparam int unsigned FrameLen = 42;
  localparam int unsigned ReplyW   = FrameLen * 8;

  typedef enum logic [1:0] {IDLE, PENDING, SENDING} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   rx_cnt_q, rx_cnt_d;
  logic              bc_q, bc_d;
  logic              uc_q, uc_d;
  logic              hdr_q, hdr_d;
  logic [47:0]       cap_mac_q, cap_mac_d;
  logic [31:0]       cap_ip_q, cap_ip_d;
  logic [47:0]       rep_smac_q, rep_smac_d;
  logic [31:0]       rep_sip_q, rep_sip_d;
  logic [47:0]       rep_mac_q, rep_mac_d;
  logic [31:0]       rep_ip_q, rep_ip_d;
  logic [CntW-1:0]   tx_idx_q, tx_idx_d;
  logic              valid_q, valid_d;
  logic [7:0]        data_q, data_d;

  logic              rx_byte_en;
  logic              accept;
  logic [7:0]        mac_byte;
  logic [7:0]        ip_byte;
  logic [7:0]        hdr_byte;
  logic [ReplyW-1:0] rep_vec;

  // Byte idx of the reply image, byte 0 in the top bits.
  function automatic logic [7:0] reply_byte(input logic [ReplyW-1:0] v,
                                            input logic [CntW-1:0]   idx);
    logic [8:0] sh;
    sh = 9'(6'd41 - idx) << 3;
    return v[sh +: 8];
  endfunction

  assign rep_vec = {rep_smac_q, rep_mac_q, 16'h0806, 16'h0001, 16'h0800,
                    8'h06, 8'h04, 16'h0002, rep_mac_q, rep_ip_q,
                    rep_smac_q, rep_sip_q};

  // Reference bytes for the field currently being received.
  always_comb begin
    mac_byte = MY_MAC[7:0];
    case (rx_cnt_q[2:0])
      3'd0:    mac_byte = MY_MAC[47:40];
      3'd1:    mac_byte = MY_MAC[39:32];
      3'd2:    mac_byte = MY_MAC[31:24];
      3'd3:    mac_byte = MY_MAC[23:16];
      3'd4:    mac_byte = MY_MAC[15:8];
      default: mac_byte = MY_MAC[7:0];
    endcase
    // Target IP occupies bytes 38..41, whose low two index bits are 2,3,0,1.
    ip_byte = MY_IPV4[7:0];
    case (rx_cnt_q[1:0])
      2'd2:    ip_byte = MY_IPV4[31:24];
      2'd3:    ip_byte = MY_IPV4[23:16];
      2'd0:    ip_byte = MY_IPV4[15:8];
      default: ip_byte = MY_IPV4[7:0];
    endcase
    hdr_byte = 8'h00;
    case (rx_cnt_q)
      6'd12, 6'd16: hdr_byte = 8'h08;
      6'd13, 6'd18: hdr_byte = 8'h06;
      6'd15, 6'd21: hdr_byte = 8'h01;
      6'd19:        hdr_byte = 8'h04;
      default:      hdr_byte = 8'h00;
    endcase
  end

  // RX parser and reply sequencer next-state logic.
  always_comb begin
    state_d    = state_q;
    rx_cnt_d   = rx_cnt_q;
    bc_d       = bc_q;
    uc_d       = uc_q;
    hdr_d      = hdr_q;
    cap_mac_d  = cap_mac_q;
    cap_ip_d   = cap_ip_q;
    rep_smac_d = rep_smac_q;
    rep_sip_d  = rep_sip_q;
    rep_mac_d  = rep_mac_q;
    rep_ip_d   = rep_ip_q;
    tx_idx_d   = tx_idx_q;
    valid_d    = valid_q;
    data_d     = data_q;

    rx_byte_en = DATA_VALID_RX && (rx_cnt_q < CntW'(FrameLen));

    if (!DATA_VALID_RX) begin
      rx_cnt_d = '0;
    end else if (rx_cnt_q != CntW'(FrameLen)) begin
      rx_cnt_d = rx_cnt_q + 6'd1;
    end

    if (rx_byte_en) begin
      if (rx_cnt_q == 6'd0) begin
        bc_d  = (DATA_RX == 8'hFF);
        uc_d  = (DATA_RX == mac_byte);
        hdr_d = 1'b1;
      end else if (rx_cnt_q < 6'd6) begin
        bc_d = bc_q && (DATA_RX == 8'hFF);
        uc_d = uc_q && (DATA_RX == mac_byte);
      end else if (rx_cnt_q >= 6'd12 && rx_cnt_q <= 6'd21) begin
        hdr_d = hdr_q && (DATA_RX == hdr_byte);
      end else if (rx_cnt_q >= 6'd22 && rx_cnt_q <= 6'd27) begin
        cap_mac_d = {cap_mac_q[39:0], DATA_RX};
      end else if (rx_cnt_q >= 6'd28 && rx_cnt_q <= 6'd31) begin
        cap_ip_d = {cap_ip_q[23:0], DATA_RX};
      end else if (rx_cnt_q >= 6'd38 && rx_cnt_q <= 6'd40) begin
        hdr_d = hdr_q && (DATA_RX == ip_byte);
      end
    end

    accept = rx_byte_en && (rx_cnt_q == 6'd41) && (bc_q || uc_q) && hdr_q &&
             (DATA_RX == ip_byte);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = PENDING;
          rep_smac_d = cap_mac_q;
          rep_sip_d  = cap_ip_q;
          rep_mac_d  = MY_MAC;
          rep_ip_d   = MY_IPV4;
          tx_idx_d   = '0;
          valid_d    = 1'b1;
          data_d     = cap_mac_q[47:40];
        end
      end
      PENDING: begin
        if (DATA_ACK_TX) begin
          state_d  = SENDING;
          tx_idx_d = 6'd1;
          data_d   = reply_byte(rep_vec, 6'd1);
        end
      end
      SENDING: begin
        if (tx_idx_q == CntW'(FrameLen - 1)) begin
          state_d  = IDLE;
          tx_idx_d = '0;
          valid_d  = 1'b0;
          data_d   = 8'h00;
        end else begin
          tx_idx_d = tx_idx_q + 6'd1;
          data_d   = reply_byte(rep_vec, tx_idx_q + 6'd1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        data_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge CLK_RX) begin
    if (ARESET) begin
      state_q    <= IDLE;
      rx_cnt_q   <= '0;
      bc_q       <= 1'b0;
      uc_q       <= 1'b0;
      hdr_q      <= 1'b0;
      cap_mac_q  <= '0;
      cap_ip_q   <= '0;
      rep_smac_q <= '0;
      rep_sip_q  <= '0;
      rep_mac_q  <= '0;
      rep_ip_q   <= '0;
      tx_idx_q   <= '0;
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      rx_cnt_q   <= rx_cnt_d;
      bc_q       <= bc_d;
      uc_q       <= uc_d;
      hdr_q      <= hdr_d;
      cap_mac_q  <= cap_mac_d;
      cap_ip_q   <= cap_ip_d;
      rep_smac_q <= rep_smac_d;
      rep_sip_q  <= rep_sip_d;
      rep_mac_q  <= rep_mac_d;
      rep_ip_q   <= rep_ip_d;
      tx_idx_q   <= tx_idx_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  assign DATA_VALID_TX = valid_q;
  assign DATA_TX       = data_q;

endmodule

// File: tb/tb_arp_response_core.sv
// Directed bench for arp_response_core: vector table of request variants plus
// hand sequences for truncation, back-pressure, drop-while-busy and reset.
module tb_arp_response_core;

  localparam logic [47:0] MyMac  = 48'h000223010203;
  localparam logic [31:0] MyIp   = 32'hC0A80102;
  localparam logic [47:0] SndMac = 48'h000142005F68;
  localparam logic [31:0] SndIp  = 32'hC0A80101;
  localparam logic [47:0] Bcast  = 48'hFFFFFFFFFFFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       ack;

  int checks = 0;
  int errors = 0;

  logic [7:0] frm     [0:41];
  logic [7:0] exp_rep [0:41];

  typedef struct {
    logic [47:0] dst;
    logic [15:0] etype;
    logic [15:0] op;
    logic [31:0] tip;
    int          nbytes;
    logic        exp;
  } vec_t;

  vec_t vecs [0:6];

  always #5 clk = ~clk;

  arp_response_core dut (
    .CLK_RX        (clk),
    .ARESET        (rst),
    .MY_MAC        (MyMac),
    .MY_IPV4       (MyIp),
    .DATA_VALID_RX (rx_valid),
    .DATA_RX       (rx_data),
    .DATA_VALID_TX (tx_valid),
    .DATA_TX       (tx_data),
    .DATA_ACK_TX   (ack)
  );

  task automatic chk1(input string name, input logic act, input logic e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, e);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] etype,
                       input logic [15:0] op, input logic [47:0] smac,
                       input logic [31:0] sip, input logic [31:0] tip);
    logic [335:0] v;
    v = {dst, smac, etype, 16'h0001, 16'h0800, 8'h06, 8'h04, op,
         smac, sip, 48'h0, tip};
    for (int i = 0; i < 42; i++) frm[i] = v[335 - 8*i -: 8];
  endtask

  // Drive nbytes at negedges (zero padding past byte 41), then one idle cycle.
  task automatic send_frame(input int nbytes, input bit lat);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      if (lat && i == 41) chk1("latency pre", tx_valid, 1'b0);
      rx_valid = 1'b1;
      rx_data  = (i < 42) ? frm[i] : 8'h00;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (lat) begin
      chk1("latency valid", tx_valid, 1'b1);
      chk8("latency byte0", tx_data, 8'h00);
    end
  endtask

  // Called at a negedge with a reply pending; rst_at>0 resets at that byte.
  task automatic recv_reply(input int rst_at);
    chk1("pend valid", tx_valid, 1'b1);
    chk8("pend byte0", tx_data, exp_rep[0]);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    for (int i = 1; i < 42; i++) begin
      chk1($sformatf("reply valid %0d", i), tx_valid, 1'b1);
      chk8($sformatf("reply byte %0d", i), tx_data, exp_rep[i]);
      if (rst_at == i) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("reset mid-reply valid", tx_valid, 1'b0);
        chk8("reset mid-reply data", tx_data, 8'h00);
        return;
      end
      @(negedge clk);
    end
    chk1("reply end valid", tx_valid, 1'b0);
    chk8("reply end data", tx_data, 8'h00);
  endtask

  initial begin
    logic [335:0] r;
    r = 336'h000142005F68_000223010203_0806_0001_0800_06_04_0002_000223010203_C0A80102_000142005F68_C0A80101;
    for (int i = 0; i < 42; i++) exp_rep[i] = r[335 - 8*i -: 8];

    vecs[0] = '{Bcast, 16'h0806, 16'h0001, 32'hC0A80102, 42, 1'b1};
    vecs[1] = '{Bcast, 16'h0806, 16'h0001, 32'hC0A80103, 42, 1'b0};
    vecs[2] = '{Bcast, 16'h0806, 16'h0002, 32'hC0A80102, 42, 1'b0};
    vecs[3] = '{Bcast, 16'h0800, 16'h0001, 32'hC0A80102, 42, 1'b0};
    vecs[4] = '{MyMac, 16'h0806, 16'h0001, 32'hC0A80102, 60, 1'b1};
    vecs[5] = '{48'h000223010204, 16'h0806, 16'h0001, 32'hC0A80102, 42, 1'b0};
    vecs[6] = '{Bcast, 16'h0806, 16'h0001, 32'hC0A80102, 41, 1'b0};

    rst = 1'b1; ack = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk1("reset valid", tx_valid, 1'b0);
    chk8("reset data", tx_data, 8'h00);
    rst = 1'b0;

    // ACK while idle must not start anything.
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    @(negedge clk);
    chk1("idle ack ignored", tx_valid, 1'b0);

    for (int v = 0; v < 7; v++) begin
      build(vecs[v].dst, vecs[v].etype, vecs[v].op, SndMac, SndIp, vecs[v].tip);
      send_frame(vecs[v].nbytes, v == 0);
      chk1($sformatf("vec%0d reply", v), tx_valid, vecs[v].exp);
      if (vecs[v].exp) recv_reply(0);
      repeat (3) @(negedge clk);
      chk1($sformatf("vec%0d idle after", v), tx_valid, 1'b0);
    end

    // Truncated frame followed by a full request: one reply.
    build(Bcast, 16'h0806, 16'h0001, SndMac, SndIp, MyIp);
    send_frame(30, 1'b0);
    chk1("truncated no reply", tx_valid, 1'b0);
    send_frame(42, 1'b0);
    recv_reply(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk1("truncated single reply", tx_valid, 1'b0);
    end

    // Second request while pending is dropped; ACK withheld 100 cycles.
    build(Bcast, 16'h0806, 16'h0001, SndMac, SndIp, MyIp);
    send_frame(42, 1'b0);
    build(Bcast, 16'h0806, 16'h0001, 48'h000142005F69, 32'hC0A80109, MyIp);
    send_frame(42, 1'b0);
    for (int i = 0; i < 100; i++) begin
      chk1("hold valid", tx_valid, 1'b1);
      chk8("hold byte0", tx_data, 8'h00);
      @(negedge clk);
    end
    recv_reply(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk1("dropped second request", tx_valid, 1'b0);
    end

    // Reset during reply byte 10, then a fresh request.
    build(Bcast, 16'h0806, 16'h0001, SndMac, SndIp, MyIp);
    send_frame(42, 1'b0);
    recv_reply(10);
    repeat (2) @(negedge clk);
    chk1("post-reset idle", tx_valid, 1'b0);
    send_frame(42, 1'b0);
    recv_reply(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
